// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state type and sizing helpers for the serial adder
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Beat counter must hold values up to WIDTH/DIGIT.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

  function automatic bit digit_divides(input int width, input int digit);
    return (digit > 0) && (width % digit == 0);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational one-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - multi-cycle add/subtract resolving DIGIT bits per clock
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import arith_pkg::*;

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(K - 1);

  if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_digit
    $error("serial_adder_n: DIGIT must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] digit_sum;
  logic [WIDTH-1:0] psum_nx;

  assign chain_c[0] = carry_q;

  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    fa_cell u_fa (
      .a    (a_q[g]),
      .b    (b_q[g]),
      .cin  (chain_c[g]),
      .sum  (digit_sum[g]),
      .cout (chain_c[g+1])
    );
  end

  // New digit enters at the MSB end so after K beats bit 0 sits at bit 0.
  assign psum_nx = (psum_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          psum_d  = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chain_c[DIGIT];
        psum_d  = psum_nx;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = DONE;
          sum_d   = psum_nx;
          cout_d  = chain_c[DIGIT];
          // On the last beat the top cell is bit WIDTH-1.
          ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and swept checks of serial_adder_n for DIGIT 1, 2, 4, 8
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;

  logic       busy_w [4];
  logic       done_w [4];
  logic [7:0] sum_w  [4];
  logic       cout_w [4];
  logic       ovf_w  [4];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder_n #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .sum   (sum_w[g]),
      .cout  (cout_w[g]),
      .ovf   (ovf_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [9:0] ref_add(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic rc, input logic rs);
    logic [7:0] bb;
    logic [8:0] s;
    logic       o;
    bb = rs ? ~rb : rb;
    s  = {1'b0, ra} + {1'b0, bb} + {8'd0, (rs ? 1'b1 : rc)};
    o  = (ra[7] == bb[7]) && (s[7] != ra[7]);
    return {o, s[8], s[7:0]};
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input logic [7:0] es, input logic ec,
                        input logic eo, input bit tamper, input logic [3:0] mask);
    int lat [4];
    int pulses [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0;
      pulses[i] = 0;
    end
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++)
      if (mask[i]) chk($sformatf("busy_after_accept[d%0d]", 1 << i), 32'(busy_w[i]), 32'd1);
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (done_w[i]) begin
          pulses[i]++;
          if (lat[i] == 0) lat[i] = n;
        end
      if (tamper && n == 3) begin
        start = 1'b1; a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
      end
      if (tamper && n == 4) start = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        chk($sformatf("sum[d%0d a=%h b=%h s=%0d]", 1 << i, ta, tb, ts), 32'(sum_w[i]), 32'(es));
        chk($sformatf("cout[d%0d a=%h b=%h s=%0d]", 1 << i, ta, tb, ts), 32'(cout_w[i]), 32'(ec));
        chk($sformatf("ovf[d%0d a=%h b=%h s=%0d]", 1 << i, ta, tb, ts), 32'(ovf_w[i]), 32'(eo));
        chk($sformatf("latency[d%0d]", 1 << i), 32'(lat[i]), 32'((8 >> i) + 1));
        chk($sformatf("done_pulses[d%0d]", 1 << i), 32'(pulses[i]), 32'd1);
      end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    logic [9:0] r;
    int         last [2];
    int         cnt  [2];
    int         nd;

    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_busy[d%0d]", 1 << i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("reset_done[d%0d]", 1 << i), 32'(done_w[i]), 32'd0);
      chk($sformatf("reset_res[d%0d]", 1 << i), {22'd0, ovf_w[i], cout_w[i], sum_w[i]}, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 4'hF);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 4'hF);
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 4'hF);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 4'hF);
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 4'hF);
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1, 4'b0011);

    // start held high: one done every K+1 cycles
    @(negedge clk);
    a = 8'h3C; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      last[i] = 0;
      cnt[i] = 0;
    end
    for (int n = 1; n <= 28; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        if (done_w[i]) begin
          if (last[i] != 0) chk($sformatf("b2b_gap[d%0d]", 1 << i), 32'(n - last[i]), 32'((8 >> i) + 1));
          last[i] = n;
          cnt[i]++;
        end
    end
    start = 1'b0;
    chk("b2b_count[d1]", 32'(cnt[0]), 32'd3);
    chk("b2b_count[d2]", 32'(cnt[1]), 32'd5);
    chk("b2b_sum[d1]", 32'(sum_w[0]), 32'h4D);
    repeat (12) @(posedge clk);

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 4'hF);

    // reset in the middle of a run
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_done", 32'(done_w[0]), 32'd0);
    chk("midrst_sum", 32'(sum_w[0]), 32'd0);
    chk("midrst_cout", 32'(cout_w[0]), 32'd0);
    chk("midrst_ovf", 32'(ovf_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done_w[0] || busy_w[0]) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 4'hF);

    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      r  = ref_add(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[7:0], r[8], r[9], 1'b0, 4'hF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder/subtractor that resolves a WIDTH-bit operation DIGIT bits per clock through a chain of single-bit full-adder cells. It trades latency for area against the flat one-bit full adder, adds a start/done handshake and a subtract mode, and reports signed overflow. It sits in the arithmetic datapath wherever a narrow, low-area add/subtract unit is enough.

## Interface
- WIDTH, 8, operand/result width; ≥ 2.
- DIGIT, 1, bits resolved per cycle; must divide WIDTH exactly; DIGIT = WIDTH gives single-cycle operation.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in add mode only.
- sub  in  1  0: A + B + cin; 1: A − B (cin ignored).
- busy  out  1  high while the operation is running.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result, registered.
- cout  out  1  carry-out of MSB; in subtract mode this is the not-borrow flag (1 = A ≥ B unsigned).
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE. K = WIDTH/DIGIT.
- IDLE or DONE with start = 1: latch A, B' = sub ? ~b : b, and carry = sub ? 1 : cin. Clear the beat counter and go to RUN.
- RUN, each cycle: the DIGIT low bits of A and B' plus carry pass through DIGIT chained cells. The result bits shift into the partial-sum register from the MSB end. Operand registers shift right by DIGIT. Carry updates, and the carry into the top cell of the final beat is captured.
- RUN after beat K: copy the partial sum to sum, set cout = final carry, set ovf = final carry XOR carry into bit WIDTH−1, then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unless start is high.
- start during RUN is ignored; there is no queueing.
- sum, cout and ovf change only on the transition into DONE. They hold until the next completion, including through later start requests.
- Inputs a, b, cin and sub are sampled only at the accept edge. Changes during RUN have no effect.

## Timing
- Reset (asynchronous, rst_n low): state = IDLE; busy, done, sum, cout, ovf all 0; internal registers 0. This applies mid-RUN too: the operation is lost and no done is produced.
- Accept edge E0: busy is high from E0.
- Beats are processed at edges E1..EK. At EK the state moves to DONE: busy falls, done rises, and the results update.
- Latency from accepting start to done = K+1 cycles. Back-to-back: a start held high in DONE is accepted at EK+1, giving a throughput of one operation per K+1 cycles.
- The combinational path per cycle is DIGIT cells of ripple; no other logic depth is added.
- Reset release is asynchronous; the first start is honoured at the first rising edge with rst_n high.

## Structure
- Shared package arith_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the counter-width constant ($clog2(WIDTH/DIGIT+1));
  - an elaboration check that WIDTH % DIGIT == 0.
- Sub-module fa_cell: combinational one-bit full adder (a, b, cin → sum, cout), instantiated DIGIT times in a generate loop.
- The top level holds the FSM, beat counter, operand/partial-sum shift registers and output registers.

## Test plan
- WIDTH=8, DIGIT=1: a=0x7F, b=0x01, cin=0, sub=0 → after 9 cycles done pulses once; sum=0x80, cout=0, ovf=1.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=1, sub=0 → sum=0x01, cout=1, ovf=0.
- WIDTH=8, DIGIT=2, subtract: a=0x05, b=0x07, sub=1 → done after 5 cycles; sum=0xFE, cout=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Handshake: start pulsed again during RUN and a/b changed mid-run → the result is unaffected and there is exactly one done. start held high continuously → done every K+1 cycles.
- Reset: assert rst_n low at beat 3 of a run → all outputs 0 immediately and no done. A following start completes normally.
- Sweep: DIGIT ∈ {1, 2, 4, 8} with WIDTH=8, random operands, cin and sub → sum, cout and ovf match the reference model; latency = WIDTH/DIGIT + 1.
